// File: rtl/drac_pkg.sv
// Shared pipeline types for the fetch/decode boundary plus fetch buffer
// configuration (default depth and control-state encoding).
package drac_pkg;

    localparam int unsigned FETCH_BUFFER_DEPTH = 4;

    typedef enum logic [4:0] {
        INSTR_ADDR_MISALIGNED = 5'd0,
        INSTR_ACCESS_FAULT    = 5'd1,
        ILLEGAL_INSTR         = 5'd2,
        BREAKPOINT            = 5'd3,
        INSTR_PAGE_FAULT      = 5'd12,
        NONE                  = 5'd31
    } exception_cause_t;

    typedef struct packed {
        exception_cause_t cause;
        logic [63:0]      origin;
        logic             valid;
    } exception_t;

    typedef struct packed {
        logic [63:0] pc_inst;
        logic [31:0] inst;
        logic        valid;
        exception_t  ex;
    } if_id_stage_t;

    typedef enum logic {
        FB_RUN,
        FB_EX_HOLD
    } fetch_buffer_state_t;

endpackage

// File: rtl/fetch_buffer_ram.sv
// Fetch buffer storage: DEPTH packets, one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fetch_buffer_ram
    import drac_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_BUFFER_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  if_id_stage_t             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output if_id_stage_t             rdata
);

    if_id_stage_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode with exception hold.
// Optional same-cycle empty-queue bypass: define FETCH_BUFFER_BYPASS_EN.
module fetch_buffer
    import drac_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_BUFFER_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  if_id_stage_t               fetch_i,
    input  logic                       stall_i,
    output logic                       full_o,
    output if_id_stage_t               decode_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;
    fetch_buffer_state_t state;
    fetch_buffer_state_t state_next;
    if_id_stage_t        head;

    logic empty;
    logic stored_valid;
    logic bypass;
    logic accept;
    logic enq;
    logic deq;

    fetch_buffer_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk_i),
        .we    (enq),
        .waddr (wr_ptr),
        .wdata (fetch_i),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign empty        = (count == '0);
    assign full_o       = (count == CNT_W'(DEPTH)) || (state == FB_EX_HOLD);
    assign count_o      = count;
    assign stored_valid = !empty && head.valid;

    // Bypass is only offered while accepting, so a held exception blocks it too
`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass = empty && fetch_i.valid && !flush_i && (state == FB_RUN);
`else
    assign bypass = 1'b0;
`endif

    assign accept = fetch_i.valid && !full_o && !flush_i;
    assign enq    = accept && !(bypass && !stall_i);
    assign deq    = stored_valid && !stall_i && !flush_i;

    always_comb begin
        decode_o       = head;
        decode_o.valid = stored_valid && !flush_i;
        if (bypass) begin
            decode_o = fetch_i;
        end
    end

    // Next-state: a faulting packet freezes intake until the next flush
    always_comb begin
        state_next = state;
        case (state)
            FB_RUN: begin
                if (accept && fetch_i.ex.valid) begin
                    state_next = FB_EX_HOLD;
                end
            end
            FB_EX_HOLD: begin
                if (flush_i) begin
                    state_next = FB_RUN;
                end
            end
            default: state_next = FB_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= FB_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_fetch_buffer;
    import drac_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         stall;
    logic         full;
    logic [2:0]   count;
    if_id_stage_t fetch;
    if_id_stage_t decode;

    int n_checks = 0;
    int n_pass   = 0;

    if_id_stage_t mq[$];
    bit           hold = 0;
    logic [63:0]  next_pc;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .flush_i  (flush),
        .fetch_i  (fetch),
        .stall_i  (stall),
        .full_o   (full),
        .decode_o (decode),
        .count_o  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model
    task automatic step(input bit v, input logic [63:0] pc, input bit ex, input bit st, input bit fl);
        if_id_stage_t p;
        if_id_stage_t exp_head;
        bit exp_full;
        bit exp_valid;
        bit bypass_hit;
        @(negedge clk);
        p           = '0;
        p.valid     = v;
        p.pc_inst   = pc;
        p.inst      = $urandom;
        p.ex.valid  = ex;
        p.ex.cause  = ex ? INSTR_PAGE_FAULT : NONE;
        p.ex.origin = pc;
        fetch = p;
        stall = st;
        flush = fl;
        #1;
        exp_full   = (mq.size() == DEPTH) || hold;
        bypass_hit = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
        bypass_hit = v && !fl && (mq.size() == 0) && !hold;
`endif
        exp_valid = !fl && ((mq.size() != 0) || bypass_hit);
        check("count", 64'(count), 64'(mq.size()));
        check("full", 64'(full), 64'(exp_full));
        check("valid", 64'(decode.valid), 64'(exp_valid));
        if (exp_valid) begin
            exp_head = bypass_hit ? p : mq[0];
            check("pc", decode.pc_inst, exp_head.pc_inst);
            check("inst", 64'(decode.inst), 64'(exp_head.inst));
            check("ex", 64'(decode.ex.valid), 64'(exp_head.ex.valid));
        end
        if (fl) begin
            mq.delete();
            hold = 1'b0;
        end else begin
            if (exp_valid && !st && !bypass_hit) begin
                void'(mq.pop_front());
            end
            if (v && !exp_full) begin
                if (!(bypass_hit && !st)) begin
                    mq.push_back(p);
                end
                if (ex) begin
                    hold = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n, input bit st);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 64'h0, 1'b0, st, 1'b0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        stall = 1'b1;
        fetch = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_valid", 64'(decode.valid), 64'd0);
        rst = 1'b0;

        // three packets under stall, then drain in order
        step(1'b1, 64'h200, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h204, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h208, 1'b0, 1'b1, 1'b0);
        idle(5, 1'b0);

        // overfill: fifth request dropped, full clears after one dequeue
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 64'h200 + 64'(4 * i), 1'b0, 1'b1, 1'b0);
        end
        idle(1, 1'b1);
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(5, 1'b0);

        // streaming with pointer wrap
        step(1'b1, 64'h1000, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 64'h1000 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
        end
        idle(3, 1'b0);

        // faulting fetch holds intake until flush
        step(1'b1, 64'h300, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h304, 1'b1, 1'b1, 1'b0);
        step(1'b1, 64'h308, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h30c, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h310, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h314, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // flush concurrent with enqueue and dequeue
        step(1'b1, 64'h500, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h504, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h508, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);

        // asynchronous reset with entries queued
        step(1'b1, 64'h600, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h604, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h608, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        fetch = '0;
        stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_full", 64'(full), 64'd0);
        check("arst_valid", 64'(decode.valid), 64'd0);
        mq.delete();
        hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;

`ifdef FETCH_BUFFER_BYPASS_EN
        step(1'b1, 64'h400, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
`endif

        // random traffic
        next_pc = 64'h8000;
        for (int i = 0; i < 600; i++) begin
            bit v;
            v = ($urandom_range(99) < 65);
            step(v, next_pc, ($urandom_range(99) < 3), ($urandom_range(99) < 35),
                 ($urandom_range(99) < 5));
            if (v) begin
                next_pc = next_pc + 64'd4;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction queue between the fetch stage and decode. It captures one `if_id_stage_t` packet per cycle from fetch and holds up to DEPTH packets. Decode pops them in order and may stall at any time. Back-pressure to fetch comes from `full_o`, which the control unit turns into the fetch stall. After a faulting fetch the queue accepts nothing more until it is flushed, so a fetch exception is always the youngest entry.

## Interface
- DEPTH, 4: number of entries. Power of two, minimum 2.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  discards all entries; driven on redirect (jump/branch/exception).
- fetch_i  in  if_id_stage_t  packet from fetch; `fetch_i.valid` requests an enqueue.
- stall_i  in  1  decode cannot accept a packet this cycle.
- full_o  out  1  count == DEPTH, or the exception-hold state is active; fetch must stall.
- decode_o  out  if_id_stage_t  head entry; `decode_o.valid` is high when an entry is presented.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH entries of `if_id_stage_t`, a read pointer and a write pointer, each $clog2(DEPTH) bits, and a count register.
- Pointers wrap modulo DEPTH by natural overflow.
- Enqueue condition: `fetch_i.valid && !full_o && !flush_i`.
  - Writes `fetch_i` at the write pointer, then increments the write pointer.
- Dequeue condition: `decode_o.valid && !stall_i && !flush_i`.
  - Increments the read pointer.
- Count update:
  - +1 on enqueue only, −1 on dequeue only.
  - Unchanged when both happen in the same cycle.
- Full: no enqueue when count == DEPTH, even if a dequeue occurs in the same cycle. `full_o` depends only on state, never on same-cycle inputs.
- Empty, same cycle enqueue: the entry is written and becomes visible next cycle. Exception: bypass mode, see Configuration.
- State machine with two states:
  - RUN to EX_HOLD: an enqueued packet has `ex.valid`=1.
  - EX_HOLD to RUN: only on `flush_i`.
  - In EX_HOLD, `full_o`=1 and no further enqueues occur. Entries already queued still drain normally.
- Flush:
  - Has priority over enqueue and dequeue.
  - Next cycle: pointers = 0, count = 0, state = RUN.
  - The input packet in the flush cycle is dropped.
  - Entry contents are not cleared.
- `decode_o`:
  - Combinational read of the head entry.
  - `decode_o.valid` = (count != 0) && stored valid bit.
  - `decode_o.valid` is forced to 0 during the flush cycle.
- Reset values: pointers 0, count 0, state RUN. Therefore `full_o`=0, `count_o`=0, `decode_o.valid`=0.
  - Entry storage is not reset.
  - Reset mid-operation discards all entries immediately.

## Timing
- Enqueue to `decode_o.valid`: 1 cycle (bypass off).
- Throughput: 1 packet/cycle with simultaneous enqueue and dequeue at any occupancy below DEPTH.
- `full_o` rises the cycle after the DEPTH-th enqueue. It falls the cycle after the first dequeue from full.
- Flush in cycle N: `decode_o.valid`=0 in N and N+1. The earliest new entry becomes visible in N+2 (bypass off).
- No combinational path from `stall_i` to `full_o`.

## Configuration
- `FETCH_BUFFER_BYPASS_EN` defined:
  - When count == 0 and `fetch_i.valid` and `!flush_i`, `decode_o` = `fetch_i` in the same cycle.
  - If `!stall_i` in that cycle, the packet is consumed and not written.
  - Otherwise it is written normally.
  - The EX_HOLD transition still applies to a bypassed packet with `ex.valid`=1.
- Not defined: no combinational path from `fetch_i` to `decode_o`. Latency is 1 cycle.

## Structure
- Into `drac_pkg`:
  - `FETCH_BUFFER_DEPTH` constant, the default for DEPTH.
  - `fetch_buffer_state_t` enum: `FB_RUN`, `FB_EX_HOLD`.
- `if_id_stage_t` is reused unchanged.
- One sub-module: `fetch_buffer_ram`, a DEPTH × `$bits(if_id_stage_t)` register file with one write port and one asynchronous read port.
- Pointer, count and FSM logic stay in `fetch_buffer`.

## Test plan
- Reset, then 3 packets with PC 0x200, 0x204, 0x208 while `stall_i`=1. Release → `count_o`=3, then decode sees 0x200, 0x204, 0x208 in consecutive cycles, then `decode_o.valid`=0.
- `stall_i`=1 and 5 requests, DEPTH=4:
  - → `full_o`=1 after the 4th; the 5th is not stored.
  - One dequeue → `full_o`=0 next cycle.
  - Order preserved, PC 0x200 first.
- Continuous enqueue and dequeue for 16 cycles → `count_o` constant, PCs contiguous, pointers wrap 4 times with no loss.
- Enqueue 0x300, then 0x304 with `ex.valid`=1 and cause INSTR_PAGE_FAULT:
  - → `full_o`=1 from the next cycle.
  - Further valid inputs are ignored; both entries drain.
  - `flush_i` → `full_o`=0.
- `flush_i` in the same cycle as an enqueue and a dequeue with 2 entries queued → next cycle `count_o`=0 and `decode_o.valid`=0; the flushed-cycle input never appears.
- `rst_i` asserted asynchronously with 3 entries queued → `count_o`=0, `full_o`=0 and `decode_o.valid`=0 before the next clock edge.
- If `FETCH_BUFFER_BYPASS_EN` is defined: empty queue, `stall_i`=0, input 0x400 → `decode_o.pc_inst`=0x400 in the same cycle and `count_o` stays 0.
